// File: rtl/ibex_l2_rf_xfer_ctrl.sv
// ibex_l2_rf_xfer_ctrl
//   Initiator for the L2 register file port. Moves a range of registers one per cycle:
//   SPILL copies main-RF registers into L2 storage, FILL copies L2 contents back into the
//   main RF. Both data paths are combinational pass-through; each write lands on the clock
//   edge that ends its XFER cycle.
//
//   Optional feature: define IBEX_L2_XFER_DIRTY_EN to add dirty_mask_i. SPILL then skips
//   registers whose mask bit is 0. Each skipped register still takes one cycle, but it does
//   not write and does not count. FILL ignores the mask.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake (ready only in IDLE)
//   cmd_fill_i               0 = SPILL (main RF -> L2), 1 = FILL (L2 -> main RF)
//   cmd_first_i/cmd_last_i   inclusive register range, normalised at accept
//   abort_i                  finish after the current XFER cycle
//   busy_o/done_o/aborted_o  status; done_o is a one-cycle pulse, aborted_o qualifies it
//   xfer_cnt_o               writes performed by the last/current command
//   l2_addr_o/l2_wdata_o/l2_we_o/l2_rdata_i           L2 RF port
//   rf_raddr_o/rf_rdata_i/rf_waddr_o/rf_wdata_o/rf_we_o  main RF ports
//   dirty_mask_i             (IBEX_L2_XFER_DIRTY_EN only) per-register SPILL enable

module ibex_l2_rf_xfer_ctrl #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NUM_WORDS = 28
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
`ifdef IBEX_L2_XFER_DIRTY_EN
  input  logic [31:0]          dirty_mask_i,
`endif
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_fill_i,
  input  logic [4:0]           cmd_first_i,
  input  logic [4:0]           cmd_last_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o,
  output logic [4:0]           xfer_cnt_o,
  output logic [4:0]           l2_addr_o,
  output logic [DataWidth-1:0] l2_wdata_o,
  output logic                 l2_we_o,
  input  logic [DataWidth-1:0] l2_rdata_i,
  output logic [4:0]           rf_raddr_o,
  input  logic [DataWidth-1:0] rf_rdata_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o
);

  localparam logic [4:0] MaxAddr = 5'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e     r_state, w_state_d;
  logic [4:0] r_cur, r_last, r_cnt;
  logic [4:0] r_l2_addr, r_rf_raddr, r_rf_waddr;
  logic       r_fill, r_aborted;

  logic [4:0] w_first, w_last;
  logic       w_empty, w_accept, w_in_xfer, w_sel, w_l2_we, w_rf_we, w_end;

  // L2 address 0 is never touched, and the top of the range is clipped to the L2 depth.
  assign w_first  = (cmd_first_i == 5'd0) ? 5'd1 : cmd_first_i;
  assign w_last   = (cmd_last_i > MaxAddr) ? MaxAddr : cmd_last_i;
  assign w_empty  = w_first > w_last;
  assign w_accept = cmd_valid_i & (r_state == StIdle);
  assign w_in_xfer = (r_state == StXfer);
  assign w_end    = (r_cur == r_last) | abort_i;

`ifdef IBEX_L2_XFER_DIRTY_EN
  logic [31:0] r_mask;
  assign w_sel = r_fill | r_mask[r_cur];
`else
  assign w_sel = 1'b1;
`endif

  assign w_l2_we = w_in_xfer & ~r_fill & w_sel;
  assign w_rf_we = w_in_xfer & r_fill;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_d = w_empty ? StDone : StXfer;
      StXfer: if (w_end) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_cur      <= 5'd0;
      r_last     <= 5'd0;
      r_cnt      <= 5'd0;
      r_l2_addr  <= 5'd0;
      r_rf_raddr <= 5'd0;
      r_rf_waddr <= 5'd0;
      r_fill     <= 1'b0;
      r_aborted  <= 1'b0;
`ifdef IBEX_L2_XFER_DIRTY_EN
      r_mask     <= 32'd0;
`endif
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_cur     <= w_first;
        r_last    <= w_last;
        r_fill    <= cmd_fill_i;
        r_cnt     <= 5'd0;
        r_aborted <= 1'b0;
`ifdef IBEX_L2_XFER_DIRTY_EN
        r_mask    <= dirty_mask_i;
`endif
      end else if (w_in_xfer) begin
        if (w_l2_we || w_rf_we) r_cnt <= r_cnt + 5'd1;
        if (!w_end) r_cur <= r_cur + 5'd1;
        r_aborted <= abort_i;
        // Remember the last driven addresses so they hold once XFER ends.
        r_l2_addr <= r_cur;
        if (r_fill) r_rf_waddr <= r_cur;
        else        r_rf_raddr <= r_cur;
      end
    end
  end

  assign cmd_ready_o = (r_state == StIdle);
  assign busy_o      = w_in_xfer;
  assign done_o      = (r_state == StDone);
  assign aborted_o   = done_o & r_aborted;
  assign xfer_cnt_o  = r_cnt;

  assign l2_addr_o  = w_in_xfer ? r_cur : r_l2_addr;
  assign rf_raddr_o = (w_in_xfer && !r_fill) ? r_cur : r_rf_raddr;
  assign rf_waddr_o = (w_in_xfer && r_fill) ? r_cur : r_rf_waddr;
  assign l2_wdata_o = (w_in_xfer && !r_fill) ? rf_rdata_i : '0;
  assign rf_wdata_o = (w_in_xfer && r_fill) ? l2_rdata_i : '0;
  assign l2_we_o    = w_l2_we;
  assign rf_we_o    = w_rf_we;

endmodule

// File: tb/tb_ibex_l2_rf_xfer_ctrl.sv
// Directed bench for ibex_l2_rf_xfer_ctrl. Models the main RF and L2 RF as arrays with
// combinational read; writes seen on the DUT ports are applied to the arrays at the
// sampling point. Define IBEX_L2_XFER_DIRTY_EN to also exercise the dirty-mask SPILL.

module tb_ibex_l2_rf_xfer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_fill_i;
  logic [4:0]  cmd_first_i, cmd_last_i;
  logic        abort_i, busy_o, done_o, aborted_o;
  logic [4:0]  xfer_cnt_o, l2_addr_o, rf_raddr_o, rf_waddr_o;
  logic [31:0] l2_wdata_o, l2_rdata_i, rf_rdata_i, rf_wdata_o;
  logic        l2_we_o, rf_we_o;
`ifdef IBEX_L2_XFER_DIRTY_EN
  logic [31:0] dirty_mask_i;
`endif

  logic [31:0] rf_mem [32];
  logic [31:0] l2_mem [32];
  logic [4:0]  l2_q[$];
  logic [4:0]  rf_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  assign rf_rdata_i = rf_mem[rf_raddr_o];
  assign l2_rdata_i = l2_mem[l2_addr_o];

  ibex_l2_rf_xfer_ctrl #(.DataWidth(32), .NUM_WORDS(28)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
`ifdef IBEX_L2_XFER_DIRTY_EN
    .dirty_mask_i(dirty_mask_i),
`endif
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_fill_i  (cmd_fill_i),
    .cmd_first_i (cmd_first_i),
    .cmd_last_i  (cmd_last_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .aborted_o   (aborted_o),
    .xfer_cnt_o  (xfer_cnt_o),
    .l2_addr_o   (l2_addr_o),
    .l2_wdata_o  (l2_wdata_o),
    .l2_we_o     (l2_we_o),
    .l2_rdata_i  (l2_rdata_i),
    .rf_raddr_o  (rf_raddr_o),
    .rf_rdata_i  (rf_rdata_i),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rf_we_o     (rf_we_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; applies any write that the coming edge performs.
  task automatic sample();
    if (l2_we_o) begin
      l2_mem[l2_addr_o] = l2_wdata_o;
      l2_q.push_back(l2_addr_o);
    end
    if (rf_we_o) begin
      rf_mem[rf_waddr_o] = rf_wdata_o;
      rf_q.push_back(rf_waddr_o);
    end
  endtask

  // Accept edge is cycle 0; done_cyc is the cycle in which done_o is seen (-1 on timeout).
  task automatic run_cmd(input logic fill, input logic [4:0] first, input logic [4:0] last,
                         input int abort_at, output int done_cyc, output logic ab);
    l2_q.delete();
    rf_q.delete();
    done_cyc = -1;
    ab = 1'b0;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_fill_i = fill; cmd_first_i = first; cmd_last_i = last;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      abort_i = (k == abort_at);
      @(negedge clk_i);
      sample();
      if (done_o) begin
        done_cyc = k;
        ab = aborted_o;
        break;
      end
      @(posedge clk_i); #1;
    end
    abort_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic chk_range(input string tag, input logic [4:0] q[$], input int lo, input int hi);
    int bad;
    bad = 0;
    chk({tag, "_nwr"}, q.size(), hi - lo + 1);
    foreach (q[i]) if (q[i] !== 5'(lo + i)) bad++;
    chk({tag, "_addr_seq"}, bad, 0);
  endtask

  initial begin
    int          dc;
    logic        ab;
    int          bad;
    int          ndone;
    int          nwr;
    logic        rdy4, rdy5, dn4, dn8;
    logic [4:0]  wa6;

    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_fill_i = 1'b0;
    cmd_first_i = 5'd0; cmd_last_i = 5'd0; abort_i = 1'b0;
`ifdef IBEX_L2_XFER_DIRTY_EN
    dirty_mask_i = 32'hFFFF_FFFF;
`endif
    for (int r = 0; r < 32; r++) begin
      rf_mem[r] = 32'hA000_0000 + r;
      l2_mem[r] = 32'h0;
    end

    // Reset values
    #12;
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_aborted", aborted_o, 0);
    chk("rst_we", {l2_we_o, rf_we_o}, 0);
    chk("rst_cnt", xfer_cnt_o, 0);
    chk("rst_addrs", {l2_addr_o, rf_raddr_o, rf_waddr_o}, 0);
    chk("rst_wdata", l2_wdata_o | rf_wdata_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // SPILL 1..27
    run_cmd(1'b0, 5'd1, 5'd27, 0, dc, ab);
    chk("spill_done_cyc", dc, 28);
    chk("spill_aborted", ab, 0);
    chk("spill_cnt", xfer_cnt_o, 27);
    chk_range("spill", l2_q, 1, 27);
    chk("spill_rf_nwr", rf_q.size(), 0);
    bad = 0;
    for (int r = 1; r <= 27; r++) if (l2_mem[r] !== 32'hA000_0000 + r) bad++;
    chk("spill_data", bad, 0);
    chk("idle_addr_hold", l2_addr_o, 27);
    chk("idle_ready", cmd_ready_o, 1);

    // FILL 5..7
    for (int r = 1; r < 32; r++) l2_mem[r] = 32'h5A5A_0000 + r;
    run_cmd(1'b1, 5'd5, 5'd7, 0, dc, ab);
    chk_range("fill", rf_q, 5, 7);
    chk("fill_l2_nwr", l2_q.size(), 0);
    chk("fill_cnt", xfer_cnt_o, 3);
    chk("fill_done_cyc", dc, 4);
    chk("fill_data6", rf_mem[6], 32'h5A5A_0006);
    chk("fill_data8_untouched", rf_mem[8], 32'hA000_0008);

    // Normalisation: 0..31 becomes 1..27
    for (int r = 0; r < 32; r++) l2_mem[r] = 32'h0;
    run_cmd(1'b0, 5'd0, 5'd31, 0, dc, ab);
    chk_range("norm", l2_q, 1, 27);
    chk("norm_done_cyc", dc, 28);
    chk("norm_l2_0_untouched", l2_mem[0], 0);

    // Empty range
    run_cmd(1'b0, 5'd9, 5'd4, 0, dc, ab);
    chk("empty_done_cyc", dc, 1);
    chk("empty_nwr", l2_q.size() + rf_q.size(), 0);
    chk("empty_cnt", xfer_cnt_o, 0);

    // Abort in 3rd XFER cycle of FILL 1..10
    for (int r = 1; r < 32; r++) l2_mem[r] = 32'h1234_0000 + r;
    run_cmd(1'b1, 5'd1, 5'd10, 3, dc, ab);
    chk_range("abort", rf_q, 1, 3);
    chk("abort_aborted", ab, 1);
    chk("abort_done_cyc", dc, 4);
    chk("abort_cnt", xfer_cnt_o, 3);
    chk("abort_data3", rf_mem[3], 32'h1234_0003);
    chk("abort_data4_untouched", rf_mem[4], 32'hA000_0004);
    chk("abort_flag_clears", aborted_o, 0);

    // cmd_valid held through a SPILL 1..3; the FILL 5..6 behind it waits for IDLE
    l2_q.delete(); rf_q.delete();
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_fill_i = 1'b0; cmd_first_i = 5'd1; cmd_last_i = 5'd3;
    @(posedge clk_i); #1;
    cmd_fill_i = 1'b1; cmd_first_i = 5'd5; cmd_last_i = 5'd6;
    rdy4 = 1'b1; rdy5 = 1'b0; dn4 = 1'b0; dn8 = 1'b0; wa6 = 5'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) cmd_valid_i = 1'b0;
      @(negedge clk_i);
      sample();
      if (k == 4) begin rdy4 = cmd_ready_o; dn4 = done_o; end
      if (k == 5) rdy5 = cmd_ready_o;
      if (k == 6) wa6 = rf_waddr_o;
      if (k == 8) dn8 = done_o;
      @(posedge clk_i); #1;
    end
    chk("held_spill_nwr", l2_q.size(), 3);
    chk("held_done_cyc4", dn4, 1);
    chk("held_ready_in_done", rdy4, 0);
    chk("held_ready_idle", rdy5, 1);
    chk("held_fill_addr", wa6, 5);
    chk("held_fill_nwr", rf_q.size(), 2);
    chk("held_done_cyc8", dn8, 1);

`ifdef IBEX_L2_XFER_DIRTY_EN
    // Dirty-mask SPILL 1..8, mask 0x54 -> registers 2,4,6
    for (int r = 0; r < 32; r++) l2_mem[r] = 32'h0;
    dirty_mask_i = 32'h0000_0054;
    run_cmd(1'b0, 5'd1, 5'd8, 0, dc, ab);
    dirty_mask_i = 32'hFFFF_FFFF;
    chk("dirty_nwr", l2_q.size(), 3);
    if (l2_q.size() == 3) begin
      chk("dirty_addr0", l2_q[0], 2);
      chk("dirty_addr1", l2_q[1], 4);
      chk("dirty_addr2", l2_q[2], 6);
    end
    chk("dirty_cnt", xfer_cnt_o, 3);
    chk("dirty_done_cyc", dc, 9);
    chk("dirty_skip3", l2_mem[3], 0);
`endif

    // Reset in the middle of a SPILL
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1; cmd_fill_i = 1'b0; cmd_first_i = 5'd1; cmd_last_i = 5'd27;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      sample();
      @(posedge clk_i); #1;
    end
    chk("midrst_busy_before", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_ready", cmd_ready_o, 1);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_we", {l2_we_o, rf_we_o}, 0);
    chk("midrst_cnt", xfer_cnt_o, 0);
    chk("midrst_addrs", {l2_addr_o, rf_raddr_o, rf_waddr_o}, 0);
    chk("midrst_wdata", l2_wdata_o, 0);
    ndone = 0;
    nwr = 0;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) ndone++;
    end
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      if (done_o) ndone++;
      if (l2_we_o || rf_we_o) nwr++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_no_writes", nwr, 0);
    chk("midrst_idle", cmd_ready_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
